core_l1i_cache: RTL and testbench
=================================

Name: core_l1i_cache

Overview:
Direct-mapped, read-only L1 instruction cache. It is the responder for the fetch stage's `if_addr_l1i_cash_out` / `if_val_l1i_cahe_out` request.
- Returns one 32-bit instruction word per accepted request.
- Stalls fetch on a miss and refills a full line from the memory-side bus.
- Supports a bulk invalidate (flush) for fence.i / self-modifying code.

Parameters:
- LINE_WORDS, 4, 32-bit words per line; power of 2, range 2..16.
- SETS, 64, number of lines; power of 2, range 2..256.
- PC_W, 32, address width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- core_req_val  input  1  fetch request valid.
- core_req_addr  input  PC_W  fetch byte address; bits [1:0] ignored.
- core_stall  output  1  cache busy; request not accepted this cycle; fetch must hold PC.
- core_rvalid  output  1  core_rdata valid this cycle.
- core_rdata  output  32  instruction word.
- flush  input  1  invalidate-all request; single-cycle pulse.
- mem_req_val  output  1  line refill request.
- mem_req_addr  output  PC_W  line-aligned refill address.
- mem_req_ack  input  1  memory accepted the request.
- mem_resp_val  input  1  refill data beat valid.
- mem_resp_data  input  32  refill data beat.

Behaviour:
- Address split:
  - word = addr[log2(LINE_WORDS)+1:2]
  - index = next log2(SETS) bits
  - tag = remaining upper bits
- Storage:
  - valid bit per set, asynchronously reset to 0.
  - tag array and data array, not reset.
- States: IDLE, LOOKUP, MISS_REQ, REFILL, REPLAY, FLUSH.
- Acceptance:
  - A request is accepted when core_req_val=1 and core_stall=0; the address is registered.
  - Requests while stalled are ignored; fetch holds them.
- IDLE/LOOKUP, one cycle after acceptance:
  - Compare the registered tag with valid&tag[index].
  - Hit: core_rvalid=1, core_rdata=word; a new request may be accepted in the same cycle (back-to-back, 1-cycle latency).
  - Miss: core_stall=1 combinationally, core_rvalid=0; go to MISS_REQ.
- MISS_REQ:
  - mem_req_val=1; mem_req_addr={tag,index,zeros}.
  - Both held stable until mem_req_ack=1, then go to REFILL.
- REFILL:
  - Beat counter starts at 0; each mem_resp_val writes data[index][cnt].
  - mem_resp_val outside REFILL is ignored.
  - On the last beat (cnt=LINE_WORDS-1): write the tag, set valid, go to REPLAY.
- REPLAY:
  - core_rvalid=1, core_rdata = the refilled requested word.
  - core_stall=0; return to IDLE, or to FLUSH if a flush is pending.
- FLUSH:
  - Clears one valid bit per cycle; set counter runs 0..SETS-1, so SETS cycles.
  - core_stall=1 throughout; then IDLE.
- Flush timing:
  - Flush in IDLE/LOOKUP: a lookup in flight completes first (hit returns data), then FLUSH.
  - Flush in MISS_REQ/REFILL: latched as pending; the refill completes and the line is written, then FLUSH runs.
- Stall: core_stall=1 in MISS_REQ, REFILL, FLUSH, and in LOOKUP on a miss.
- Reset values:
  - state=IDLE; all valid=0.
  - core_rvalid=0, core_stall=0, mem_req_val=0, mem_req_addr=0, core_rdata=0.
  - Beat/set counters=0; flush pending=0.
- Reset mid-refill: refill aborted, line stays invalid, remaining beats ignored.

Optional Feature:
- Macro: CORE_L1I_STATS_EN.
- Defined:
  - Adds outputs stat_hits[31:0] and stat_misses[31:0], reset 0.
  - hits increment on each LOOKUP hit; misses increment on entry to MISS_REQ.
  - Both wrap at 2^32 and are cleared by flush.
- Undefined: neither port nor counters exist; behaviour otherwise identical.

Test Plan:
1. Reset, req 0x0000_0200 -> core_stall=1, mem_req_addr=0x200; ack, beats 0xA0,0xA1,0xA2,0xA3 -> REPLAY cycle core_rvalid=1, core_rdata=0xA0.
2. After 1, reqs 0x204, 0x208, 0x20C back-to-back -> rdata 0xA1,0xA2,0xA3 each one cycle after acceptance, no mem_req_val.
3. After 1, req 0x600 (same index, different tag) -> miss, refill 0xB0..0xB3; then req 0x200 -> miss again (evicted).
4. mem_req_ack held low 5 cycles -> mem_req_val=1 and mem_req_addr stable all 5 cycles, core_stall=1.
5. Flush pulse after 1 -> core_stall=1 for exactly 64 cycles; then req 0x200 -> miss.
6. rst_n low during beat 2 of a refill -> outputs at reset values immediately; after release, req 0x200 misses; stray mem_resp_val ignored.

Source files
------------

// File: rtl/core_l1i_cache.sv
// core_l1i_cache
//
// Direct-mapped, read-only L1 instruction cache serving the fetch stage.
// Each accepted request returns one 32-bit word. A hit answers one cycle
// after acceptance, and a new request can be taken in that same cycle. A miss
// stalls fetch, refills the whole line from the memory bus, then replays the
// requested word. A flush pulse clears every valid bit, one set per cycle.
//
// Ports:
//   clk, rst_n                  clock; asynchronous active-low reset
//   core_req_val/core_req_addr  fetch request (byte address, bits [1:0] ignored)
//   core_stall                  request not accepted this cycle; fetch holds PC
//   core_rvalid/core_rdata      returned instruction word
//   flush                       invalidate-all pulse
//   mem_req_val/mem_req_addr    line refill request (line-aligned address)
//   mem_req_ack                 memory accepted the refill request
//   mem_resp_val/mem_resp_data  refill data beats, word 0 first
//
// Optional build macro CORE_L1I_STATS_EN adds the stat_hits / stat_misses
// counters. Both counters are cleared by flush.

module core_l1i_cache #(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64,
  parameter int PC_W       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            core_req_val,
  input  logic [PC_W-1:0] core_req_addr,
  output logic            core_stall,
  output logic            core_rvalid,
  output logic [31:0]     core_rdata,
  input  logic            flush,
  output logic            mem_req_val,
  output logic [PC_W-1:0] mem_req_addr,
  input  logic            mem_req_ack,
  input  logic            mem_resp_val,
  input  logic [31:0]     mem_resp_data
`ifdef CORE_L1I_STATS_EN
  ,
  output logic [31:0]     stat_hits,
  output logic [31:0]     stat_misses
`endif
);

  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int OFF_W  = WORD_W + 2;
  localparam int TAG_W  = PC_W - IDX_W - OFF_W;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MISS_REQ, REFILL, REPLAY, FLUSH
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:2]   addr_q, addr_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic [WORD_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0]  set_cnt_q, set_cnt_d;
  logic              flush_pend_q, flush_pend_d;

  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [31:0]       data_mem [SETS*LINE_WORDS];

  logic [WORD_W-1:0] req_word;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic              flush_any;
  logic              data_we;
  logic              tag_we;
  logic [31:0]       rd_word;
  logic              unused_addr_bits;

  assign unused_addr_bits = &{1'b0, core_req_addr[1:0]};

  assign req_word  = addr_q[OFF_W-1:2];
  assign req_idx   = addr_q[OFF_W +: IDX_W];
  assign req_tag   = addr_q[PC_W-1 -: TAG_W];
  assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign rd_word   = data_mem[{req_idx, req_word}];
  assign flush_any = flush | flush_pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      valid_q      <= '0;
      beat_cnt_q   <= '0;
      set_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      beat_cnt_q   <= beat_cnt_d;
      set_cnt_q    <= set_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Tag and data arrays have no reset. The valid bits alone decide whether a
  // line can hit.
  always_ff @(posedge clk) begin
    if (data_we) data_mem[{req_idx, beat_cnt_q}] <= mem_resp_data;
    if (tag_we)  tag_mem[req_idx] <= req_tag;
  end

  // A hit or replay cycle with a flush due goes straight to FLUSH. It also
  // stalls, so that no new request is accepted and then dropped.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    valid_d      = valid_q;
    beat_cnt_d   = beat_cnt_q;
    set_cnt_d    = set_cnt_q;
    flush_pend_d = flush_pend_q | flush;
    core_stall   = 1'b0;
    core_rvalid  = 1'b0;
    core_rdata   = '0;
    mem_req_val  = 1'b0;
    mem_req_addr = '0;
    data_we      = 1'b0;
    tag_we       = 1'b0;

    case (state_q)
      IDLE: begin
        if (core_req_val) begin
          addr_d  = core_req_addr[PC_W-1:2];
          state_d = LOOKUP;
        end else if (flush_any) begin
          state_d      = FLUSH;
          set_cnt_d    = '0;
          flush_pend_d = 1'b0;
        end
      end
      LOOKUP, REPLAY: begin
        if (state_q == REPLAY || hit) begin
          core_rvalid = 1'b1;
          core_rdata  = rd_word;
          if (flush_any) begin
            core_stall   = 1'b1;
            state_d      = FLUSH;
            set_cnt_d    = '0;
            flush_pend_d = 1'b0;
          end else if (core_req_val) begin
            addr_d  = core_req_addr[PC_W-1:2];
            state_d = LOOKUP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          core_stall = 1'b1;
          state_d    = MISS_REQ;
        end
      end
      MISS_REQ: begin
        core_stall   = 1'b1;
        mem_req_val  = 1'b1;
        mem_req_addr = {req_tag, req_idx, {OFF_W{1'b0}}};
        if (mem_req_ack) begin
          state_d    = REFILL;
          beat_cnt_d = '0;
        end
      end
      REFILL: begin
        core_stall = 1'b1;
        if (mem_resp_val) begin
          data_we = 1'b1;
          if (beat_cnt_q == WORD_W'(LINE_WORDS-1)) begin
            tag_we           = 1'b1;
            valid_d[req_idx] = 1'b1;
            state_d          = REPLAY;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        core_stall         = 1'b1;
        flush_pend_d       = 1'b0;
        valid_d[set_cnt_q] = 1'b0;
        if (set_cnt_q == IDX_W'(SETS-1)) begin
          state_d = IDLE;
        end else begin
          set_cnt_d = set_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CORE_L1I_STATS_EN
  logic [31:0] stat_hits_q, stat_hits_d;
  logic [31:0] stat_misses_q, stat_misses_d;

  // A miss is counted in the LOOKUP cycle that heads into MISS_REQ.
  always_comb begin
    stat_hits_d   = stat_hits_q;
    stat_misses_d = stat_misses_q;
    if (flush) begin
      stat_hits_d   = '0;
      stat_misses_d = '0;
    end else if (state_q == LOOKUP) begin
      if (hit) stat_hits_d   = stat_hits_q + 32'd1;
      else     stat_misses_d = stat_misses_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
    end else begin
      stat_hits_q   <= stat_hits_d;
      stat_misses_q <= stat_misses_d;
    end
  end

  assign stat_hits   = stat_hits_q;
  assign stat_misses = stat_misses_q;
`endif

endmodule

// File: tb/tb_core_l1i_cache.sv
// tb_core_l1i_cache
//
// Directed testbench for core_l1i_cache with default parameters
// (4 words per line, 64 sets, 32-bit addresses).
// - Single-cycle scenarios come from a vector table. Each record holds the
//   inputs for one cycle and the outputs expected in that cycle.
// - The flush and reset-mid-refill scenarios are written out by hand.
// - Inputs change 1 ns after the rising edge. Outputs are sampled on the
//   falling edge.

module tb_core_l1i_cache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req_val;
  logic [31:0] core_req_addr;
  logic        core_stall;
  logic        core_rvalid;
  logic [31:0] core_rdata;
  logic        flush;
  logic        mem_req_val;
  logic [31:0] mem_req_addr;
  logic        mem_req_ack;
  logic        mem_resp_val;
  logic [31:0] mem_resp_data;

  int tests_run    = 0;
  int tests_failed = 0;

  core_l1i_cache dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .core_req_val  (core_req_val),
    .core_req_addr (core_req_addr),
    .core_stall    (core_stall),
    .core_rvalid   (core_rvalid),
    .core_rdata    (core_rdata),
    .flush         (flush),
    .mem_req_val   (mem_req_val),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ack   (mem_req_ack),
    .mem_resp_val  (mem_resp_val),
    .mem_resp_data (mem_resp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        val;
    logic [31:0] addr;
    logic        ack;
    logic        rv;
    logic [31:0] rdat;
    logic        e_stall;
    logic        e_rvalid;
    logic [31:0] e_rdata;
    logic        e_mreq;
    logic [31:0] e_maddr;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(logic val, logic [31:0] addr, logic ack, logic rv,
                                 logic [31:0] rdat, logic e_stall, logic e_rvalid,
                                 logic [31:0] e_rdata, logic e_mreq, logic [31:0] e_maddr);
    vec_t v;
    v.val = val; v.addr = addr; v.ack = ack; v.rv = rv; v.rdat = rdat;
    v.e_stall = e_stall; v.e_rvalid = e_rvalid; v.e_rdata = e_rdata;
    v.e_mreq = e_mreq; v.e_maddr = e_maddr;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(logic val, logic [31:0] addr, logic flsh, logic ack,
                               logic rv, logic [31:0] rdat);
    core_req_val  = val;
    core_req_addr = addr;
    flush         = flsh;
    mem_req_ack   = ack;
    mem_resp_val  = rv;
    mem_resp_data = rdat;
  endtask

  task automatic cmp(string nm, string fld, logic [31:0] got, logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s %s: got 0x%0h, expected 0x%0h", nm, fld, got, want);
    end
  endtask

  // rdata is checked only on valid cycles, and mem_req_addr only while a
  // request is expected.
  task automatic checkOutput(string nm, logic e_stall, logic e_rvalid, logic [31:0] e_rdata,
                             logic e_mreq, logic [31:0] e_maddr);
    cmp(nm, "core_stall", {31'd0, core_stall}, {31'd0, e_stall});
    cmp(nm, "core_rvalid", {31'd0, core_rvalid}, {31'd0, e_rvalid});
    cmp(nm, "mem_req_val", {31'd0, mem_req_val}, {31'd0, e_mreq});
    if (e_rvalid) cmp(nm, "core_rdata", core_rdata, e_rdata);
    if (e_mreq)   cmp(nm, "mem_req_addr", mem_req_addr, e_maddr);
  endtask

  task automatic checkReset(string nm);
    cmp(nm, "core_stall", {31'd0, core_stall}, 32'd0);
    cmp(nm, "core_rvalid", {31'd0, core_rvalid}, 32'd0);
    cmp(nm, "core_rdata", core_rdata, 32'd0);
    cmp(nm, "mem_req_val", {31'd0, mem_req_val}, 32'd0);
    cmp(nm, "mem_req_addr", mem_req_addr, 32'd0);
  endtask

  task automatic stepCheck(string nm, logic val, logic [31:0] addr, logic flsh, logic ack,
                           logic rv, logic [31:0] rdat, logic e_stall, logic e_rvalid,
                           logic [31:0] e_rdata, logic e_mreq, logic [31:0] e_maddr);
    @(posedge clk); #1;
    applyStimulus(val, addr, flsh, ack, rv, rdat);
    @(negedge clk);
    checkOutput(nm, e_stall, e_rvalid, e_rdata, e_mreq, e_maddr);
  endtask

  initial begin
    int n;

    // Table columns:
    //   inputs:   val, addr, ack, rv, rdat
    //   expected: stall, rvalid, rdata, mreq, maddr
    // Miss on 0x200, refill A0..A3, replay word 0.
    addVec(1, 32'h200, 0, 0, 0,      0, 0, 0,      0, 0);
    addVec(1, 32'h200, 0, 0, 0,      1, 0, 0,      0, 0);
    addVec(1, 32'h200, 1, 0, 0,      1, 0, 0,      1, 32'h200);
    addVec(1, 32'h200, 0, 1, 32'hA0, 1, 0, 0,      0, 0);
    addVec(1, 32'h200, 0, 1, 32'hA1, 1, 0, 0,      0, 0);
    addVec(1, 32'h200, 0, 1, 32'hA2, 1, 0, 0,      0, 0);
    addVec(1, 32'h200, 0, 1, 32'hA3, 1, 0, 0,      0, 0);
    addVec(0, 0,       0, 0, 0,      0, 1, 32'hA0, 0, 0);
    // Back-to-back hits on the same line.
    addVec(1, 32'h204, 0, 0, 0,      0, 0, 0,      0, 0);
    addVec(1, 32'h208, 0, 0, 0,      0, 1, 32'hA1, 0, 0);
    addVec(1, 32'h20C, 0, 0, 0,      0, 1, 32'hA2, 0, 0);
    addVec(0, 0,       0, 0, 0,      0, 1, 32'hA3, 0, 0);
    addVec(0, 0,       0, 0, 0,      0, 0, 0,      0, 0);
    // 0x600 evicts 0x200 (same index, tag 1); 0x200 then misses again.
    addVec(1, 32'h600, 0, 0, 0,      0, 0, 0,      0, 0);
    addVec(1, 32'h600, 0, 0, 0,      1, 0, 0,      0, 0);
    addVec(1, 32'h600, 1, 0, 0,      1, 0, 0,      1, 32'h600);
    addVec(1, 32'h600, 0, 1, 32'hB0, 1, 0, 0,      0, 0);
    addVec(1, 32'h600, 0, 1, 32'hB1, 1, 0, 0,      0, 0);
    addVec(1, 32'h600, 0, 1, 32'hB2, 1, 0, 0,      0, 0);
    addVec(1, 32'h600, 0, 1, 32'hB3, 1, 0, 0,      0, 0);
    addVec(0, 0,       0, 0, 0,      0, 1, 32'hB0, 0, 0);
    addVec(1, 32'h200, 0, 0, 0,      0, 0, 0,      0, 0);
    addVec(1, 32'h200, 0, 0, 0,      1, 0, 0,      0, 0);
    addVec(1, 32'h200, 1, 0, 0,      1, 0, 0,      1, 32'h200);
    addVec(1, 32'h200, 0, 1, 32'hA0, 1, 0, 0,      0, 0);
    addVec(1, 32'h200, 0, 1, 32'hA1, 1, 0, 0,      0, 0);
    addVec(1, 32'h200, 0, 1, 32'hA2, 1, 0, 0,      0, 0);
    addVec(1, 32'h200, 0, 1, 32'hA3, 1, 0, 0,      0, 0);
    addVec(0, 0,       0, 0, 0,      0, 1, 32'hA0, 0, 0);
    // 0x100C misses and ack is held low for 5 cycles. The replay returns
    // word 3 of the line.
    addVec(1, 32'h100C, 0, 0, 0,      0, 0, 0,      0, 0);
    addVec(1, 32'h100C, 0, 0, 0,      1, 0, 0,      0, 0);
    for (int i = 0; i < 5; i++)
      addVec(1, 32'h100C, 0, 0, 0,    1, 0, 0,      1, 32'h1000);
    addVec(1, 32'h100C, 1, 0, 0,      1, 0, 0,      1, 32'h1000);
    addVec(1, 32'h100C, 0, 1, 32'hC0, 1, 0, 0,      0, 0);
    addVec(1, 32'h100C, 0, 1, 32'hC1, 1, 0, 0,      0, 0);
    addVec(1, 32'h100C, 0, 1, 32'hC2, 1, 0, 0,      0, 0);
    addVec(1, 32'h100C, 0, 1, 32'hC3, 1, 0, 0,      0, 0);
    addVec(0, 0,        0, 0, 0,      0, 1, 32'hC3, 0, 0);
    // 0x200 still hits after the other set was filled. A stray beat in
    // IDLE is ignored.
    addVec(1, 32'h200, 0, 0, 0,      0, 0, 0,      0, 0);
    addVec(0, 0,       0, 0, 0,      0, 1, 32'hA0, 0, 0);
    addVec(0, 0,       0, 1, 32'hFF, 0, 0, 0,      0, 0);

    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkReset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      applyStimulus(vecs[i].val, vecs[i].addr, 1'b0, vecs[i].ack, vecs[i].rv, vecs[i].rdat);
      @(negedge clk);
      checkOutput($sformatf("vec[%0d]", i), vecs[i].e_stall, vecs[i].e_rvalid,
                  vecs[i].e_rdata, vecs[i].e_mreq, vecs[i].e_maddr);
    end

    // Flush from IDLE: stall must last exactly 64 cycles, and 0x200 must
    // miss afterwards.
    stepCheck("flush_pulse", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    n = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      if (!core_stall) break;
      n++;
    end
    cmp("flush", "stall_cycles", n, 64);
    stepCheck("post_flush_req", 1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stepCheck("post_flush_miss", 1, 32'h200, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    // Reset asserted during beat 2 of the refill, with stray beats after it.
    stepCheck("abort_mreq", 1, 32'h200, 0, 1, 0, 0, 1, 0, 0, 1, 32'h200);
    stepCheck("abort_beat0", 1, 32'h200, 0, 0, 1, 32'hD0, 1, 0, 0, 0, 0);
    stepCheck("abort_beat1", 1, 32'h200, 0, 0, 1, 32'hD1, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    applyStimulus(1, 32'h200, 0, 0, 1, 32'hD2);
    rst_n = 1'b0;
    #1;
    checkReset("reset_mid_refill");
    @(posedge clk); #1;
    applyStimulus(0, 0, 0, 0, 1, 32'hD3);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_stray", 0, 0, 0, 0, 0);
    stepCheck("stray_beat", 0, 0, 0, 0, 1, 32'hEF, 0, 0, 0, 0, 0);
    stepCheck("rereq", 1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stepCheck("rereq_miss", 1, 32'h200, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    stepCheck("rereq_mreq", 1, 32'h200, 0, 1, 0, 0, 1, 0, 0, 1, 32'h200);
    stepCheck("rereq_beat0", 1, 32'h200, 0, 0, 1, 32'hE0, 1, 0, 0, 0, 0);
    stepCheck("rereq_beat1", 1, 32'h200, 0, 0, 1, 32'hE1, 1, 0, 0, 0, 0);
    stepCheck("rereq_beat2", 1, 32'h200, 0, 0, 1, 32'hE2, 1, 0, 0, 0, 0);
    stepCheck("rereq_beat3", 1, 32'h200, 0, 0, 1, 32'hE3, 1, 0, 0, 0, 0);
    stepCheck("rereq_replay", 0, 0, 0, 0, 0, 0, 0, 1, 32'hE0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
